// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot or auto-reload behaviour, a registered
// one-cycle terminal-count pulse and a sticky done flag.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             reload_en,
  input  logic             out_en,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] rld;

  // Zero count either restarts from the reload value or parks at zero;
  // it never borrows through to all-ones.
  function automatic logic [WIDTH-1:0] next_count(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] reload_val,
    input logic             auto_reload
  );
    if (cur != ZERO)
      return cur - ONE;
    else if (auto_reload)
      return reload_val;
    else
      return ZERO;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      rld  <= '0;
      tc   <= 1'b0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= data_in;
      rld  <= data_in;
      tc   <= 1'b0;
      done <= 1'b0;
    end else if (en) begin
      cnt <= next_count(cnt, rld, reload_en);
      // Only a genuine 1 -> 0 step terminates a count.
      tc  <= (cnt == ONE);
      if (cnt == ONE)
        done <= 1'b1;
    end else begin
      tc <= 1'b0;
    end
  end

  assign data_out = (out_en && !rst) ? cnt : ZERO;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed bench for countdown_timer, checked against a
// cycle-level behavioural model of the timer rules.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       reload_en = 1'b0;
  logic       out_en = 1'b1;
  logic [7:0] data_out;
  logic       tc;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_cnt  = 0;
  int m_rld  = 0;
  bit m_tc   = 0;
  bit m_done = 0;
  int tc_seen = 0;

  countdown_timer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in),
    .reload_en(reload_en), .out_en(out_en), .data_out(data_out),
    .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rld = 0; m_tc = 0; m_done = 0;
  endtask

  // One clock of the timer rules, in plain integer arithmetic.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (load) begin
      m_cnt = data_in; m_rld = data_in; m_tc = 0; m_done = 0;
    end else if (en) begin
      m_tc = (m_cnt == 1);
      if (m_cnt == 1) m_done = 1;
      if (m_cnt > 0)      m_cnt = m_cnt - 1;
      else if (reload_en) m_cnt = m_rld;
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".data_out"}, 32'(data_out), out_en ? 32'(m_cnt) : 32'd0);
    chk({tag, ".tc"}, 32'(tc), 32'(m_tc));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    if (tc === 1'b1) tc_seen++;
    check_outputs(tag);
  endtask

  // Raise reset between edges and confirm outputs clear without a clock.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    load = 1'b1; en = 1'b1; data_in = 8'h5A;
    step({tag, ".held"});
    load = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #1;
    model_reset();
    check_outputs("reset");
    @(posedge clk); #1;
    check_outputs("reset_edge");
    rst = 1'b0;

    // data_out reads 0 during reset with cnt loaded to 0x37
    out_en = 1'b1; load = 1'b1; en = 1'b0; data_in = 8'h37;
    step("load37");
    load = 1'b0; en = 1'b1;
    async_reset("rst37");
    en = 1'b0;
    step("idle_after_rst");

    // one-shot from 3
    load = 1'b1; data_in = 8'h03; reload_en = 1'b0;
    step("os_load");
    load = 1'b0; en = 1'b1; tc_seen = 0;
    for (int i = 0; i < 8; i++) step("oneshot");
    chk("oneshot.tc_count", 32'(tc_seen), 32'd1);

    // auto-reload from 2
    load = 1'b1; data_in = 8'h02; reload_en = 1'b1;
    step("ar_load");
    load = 1'b0; tc_seen = 0;
    for (int i = 0; i < 9; i++) step("autoreload");
    chk("autoreload.tc_count", 32'(tc_seen), 32'd3);

    // load wins over a same-cycle 1 -> 0 decrement
    load = 1'b1; data_in = 8'h01;
    step("pri_pre");
    data_in = 8'hA5; en = 1'b1;
    step("priority");
    chk("priority.cnt", 32'(data_out), 32'hA5);
    load = 1'b0;

    // loading zero never terminates, either mode
    for (int r = 0; r < 2; r++) begin
      load = 1'b1; data_in = 8'h00; reload_en = r[0];
      step("zero_load");
      load = 1'b0; tc_seen = 0;
      for (int i = 0; i < 5; i++) step("zero");
      chk("zero.tc_count", 32'(tc_seen), 32'd0);
    end

    // full-scale count: tc lands 255 enabled cycles after loading 0xFF
    load = 1'b1; data_in = 8'hFF; reload_en = 1'b0;
    step("ff_load");
    load = 1'b0; tc_seen = 0;
    for (int i = 0; i < 254; i++) step("ff");
    chk("ff.no_early_tc", 32'(tc_seen), 32'd0);
    step("ff_last");
    chk("ff.tc_at_255", 32'(tc), 32'd1);

    // output gating while counting
    load = 1'b1; data_in = 8'h06; reload_en = 1'b1;
    step("gate_load");
    load = 1'b0;
    for (int i = 0; i < 12; i++) begin
      out_en = i[0];
      step("gating");
    end
    out_en = 1'b1;

    // randomized traffic with occasional mid-count resets
    for (int i = 0; i < 3000; i++) begin
      load      = ($urandom_range(0, 19) == 0);
      data_in   = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      en        = ($urandom_range(0, 3) != 0);
      reload_en = 1'($urandom);
      out_en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 249) == 0) async_reset("rand_rst");
      else step("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: WIDTH, default 8, counter/data width in bits.
REQ-002 Port: clk  input  1  rising-edge clock; the block has one clock.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: en  input  1  count-enable; decrement when high.
REQ-005 Port: load  input  1  load data_in into counter and reload register.
REQ-006 Port: data_in  input  WIDTH  load value.
REQ-007 Port: reload_en  input  1  1 = auto-reload at zero, 0 = one-shot.
REQ-008 Port: out_en  input  1  output enable for data_out.
REQ-009 Port: data_out  output  WIDTH  current count, gated by out_en.
REQ-010 Port: tc  output  1  terminal-count pulse, one cycle, registered.
REQ-011 Port: done  output  1  sticky terminal-count flag, registered.

Function
REQ-012 Internal state SHALL be cnt[WIDTH-1:0], rld[WIDTH-1:0], tc and done; all updates on the rising edge of clk.
REQ-013 data_out SHALL be combinational: cnt when out_en=1, all-zero when out_en=0; out_en SHALL not affect any state.
REQ-014 Priority per cycle SHALL be: load > en > hold.
REQ-015 load=1: cnt<=data_in, rld<=data_in, done<=0, tc<=0, regardless of en and reload_en.
REQ-016 load=0, en=1, cnt>1: cnt<=cnt-1, tc<=0.
REQ-017 load=0, en=1, cnt==1: cnt<=0, tc<=1 for exactly the following cycle, done<=1.
REQ-018 load=0, en=1, cnt==0, reload_en=1: cnt<=rld, tc<=0; no wrap to all-ones ever.
REQ-019 load=0, en=1, cnt==0, reload_en=0: cnt holds 0, tc<=0 (one-shot; no further tc).
REQ-020 load=0, en=0: cnt, rld, done hold; tc<=0.
REQ-021 tc SHALL assert only on a 1->0 decrement; loading 0 or reloading rld==0 SHALL never assert tc or set done.
REQ-022 Reload period with reload_en=1 and en held high SHALL be rld+1 cycles between tc pulses (rld>=1).
REQ-023 done SHALL stay 1 until the next load or reset, independent of en and reload_en.
REQ-024 reload_en SHALL be sampled each cycle; changing it mid-count affects only the next cnt==0 decision.
REQ-025 Arithmetic SHALL be unsigned, WIDTH bits, no carry/borrow output.

Reset
REQ-026 rst=1 SHALL asynchronously force cnt=0, rld=0, tc=0, done=0 without waiting for a clock edge.
REQ-027 While rst=1, load/en SHALL be ignored; data_out SHALL read 0 regardless of out_en.
REQ-028 Reset asserted mid-count SHALL abort the count; after release the block is idle at cnt=0 until load.
REQ-029 First state change after rst deasserts SHALL occur on the first rising clk edge with rst=0.

Verification
REQ-030 Reset: rst=1 mid-count with cnt=0x37, out_en=1 -> data_out=0x00, tc=0, done=0 immediately, before next edge.
REQ-031 One-shot: load 0x03, reload_en=0, en=1 -> data_out 3,2,1,0,0,...; tc=1 exactly one cycle when cnt reaches 0; done stays 1.
REQ-032 Auto-reload: load 0x02, reload_en=1, en=1 for 9 cycles -> cnt 2,1,0,2,1,0,2,1,0; tc pulses every 3 cycles; done=1 after first.
REQ-033 Priority: cnt=0x01, en=1 and load=1 with data_in=0xA5 same cycle -> cnt=0xA5, tc=0, done=0.
REQ-034 Zero/edge: load 0x00 with en=1 (either reload_en) -> cnt stays 0, tc never 1, done stays 0; load 0xFF counts 255 cycles to tc.
REQ-035 Gating: out_en toggled during counting -> data_out alternates cnt/0x00; cnt sequence and tc timing unchanged.
